// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES encrypt/decrypt engine with valid/ready handshake.
// Evaluates ROUNDS_PER_CYCLE Feistel rounds per clock, so a block takes
// LAT = 16/ROUNDS_PER_CYCLE compute cycles. One block is in flight at a time.
// Optional CBC chaining register is compiled in with `define DES_ITER_CBC_EN.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake; dec, key, data_in sampled at acceptance
//   iv_load, iv_in       chaining-register load (CBC builds only, ignored otherwise)
//   out_valid/out_ready  output handshake; data_out held until taken
//   busy                 high while a block is running or waiting to be taken
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a block, in_ready high
// RUN   | applying ROUNDS_PER_CYCLE rounds per clock
// DONE  | result on data_out, out_valid high until out_ready

module des_iter_core #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        dec,
   input  logic [63:0] key,
   input  logic [63:0] data_in,
   input  logic        iv_load,
   input  logic [63:0] iv_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] data_out,
   output logic        busy
);

   localparam int         LAT      = 16 / ROUNDS_PER_CYCLE;
   localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CYCLE);
   localparam logic [4:0] CNT_LAST = 5'((LAT - 1) * ROUNDS_PER_CYCLE);

   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
         ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rpc
      $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   // Permutation tables use DES bit numbering: 1 = MSB of the source word.
   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Cumulative left rotation of C/D before round n, so any subkey can be
   // derived directly from the PC1 output without stepping the schedule.
   localparam int SHIFT_T [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

   // Eight S-boxes, 64 entries each, indexed by {row, col}.
   localparam int SBOX [512] = '{
      14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
      15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
      10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
       7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
       2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
      12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
       4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
      13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11};

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
      return y;
   endfunction

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] y;
      for (int i = 0; i < 56; i++) y[55-i] = k[64-PC1_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] subkey(input logic [55:0] cd, input logic [3:0] idx);
      logic [55:0] c2;
      logic [55:0] d2;
      logic [55:0] rot;
      logic [47:0] k;
      int          s;
      s   = SHIFT_T[idx];
      c2  = {cd[55:28], cd[55:28]} << s;
      d2  = {cd[27:0], cd[27:0]} << s;
      rot = {c2[55:28], d2[55:28]};
      for (int i = 0; i < 48; i++) k[47-i] = rot[56-PC2_T[i]];
      return k;
   endfunction

   function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] e;
      logic [31:0] s;
      logic [31:0] y;
      logic [5:0]  b;
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ k;
      for (int j = 0; j < 8; j++) begin
         b = e[47-6*j -: 6];
         s[31-4*j -: 4] = 4'(SBOX[j*64 + int'({b[5], b[0], b[4:1]})]);
      end
      for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
      return y;
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_l;
   logic [31:0] r_r;
   logic [55:0] r_cd;
   logic        r_dec;
   logic        r_in_ready;
   logic        r_out_valid;
   logic        r_busy;
   logic [63:0] r_data_out;

   logic [63:0] w_blk_in;
   logic [63:0] w_ip;
   logic [31:0] w_l;
   logic [31:0] w_r;
   logic [31:0] w_tmp;
   logic [3:0]  w_idx;
   logic [3:0]  w_kidx;
   logic [63:0] w_res;
   logic [63:0] w_out;

`ifdef DES_ITER_CBC_EN
   logic [63:0] r_c;
   logic [63:0] r_ct;
   logic [63:0] w_c_eff;

   // An IV loaded in the acceptance cycle applies to that same block.
   assign w_c_eff  = iv_load ? iv_in : r_c;
   assign w_blk_in = dec ? data_in : (data_in ^ w_c_eff);
   assign w_out    = r_dec ? (w_res ^ r_c) : w_res;
`else
   logic w_unused_iv;

   assign w_unused_iv = ^{iv_load, iv_in};
   assign w_blk_in    = data_in;
   assign w_out       = w_res;
`endif

   assign w_ip = perm_ip(w_blk_in);

   // Decrypt walks the schedule backwards: K16..K1 is index 15-n, i.e. ~n.
   always_comb begin
      w_l    = r_l;
      w_r    = r_r;
      w_tmp  = '0;
      w_idx  = '0;
      w_kidx = '0;
      for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
         w_idx  = r_cnt[3:0] + 4'(k);
         w_kidx = r_dec ? ~w_idx : w_idx;
         w_tmp  = w_r;
         w_r    = w_l ^ feistel(w_r, subkey(r_cd, w_kidx));
         w_l    = w_tmp;
      end
   end

   // Halves swapped before the final permutation.
   assign w_res = perm_fp({w_r, w_l});

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_l         <= '0;
         r_r         <= '0;
         r_cd        <= '0;
         r_dec       <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_data_out  <= '0;
`ifdef DES_ITER_CBC_EN
         r_c         <= '0;
         r_ct        <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
`ifdef DES_ITER_CBC_EN
               if (iv_load) r_c <= iv_in;
`endif
               if (in_valid) begin
                  r_l        <= w_ip[63:32];
                  r_r        <= w_ip[31:0];
                  r_cd       <= pc1(key);
                  r_dec      <= dec;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_RUN;
`ifdef DES_ITER_CBC_EN
                  r_c        <= w_c_eff;
                  r_ct       <= data_in;
`endif
               end
            end
            S_RUN: begin
               r_l   <= w_l;
               r_r   <= w_r;
               r_cnt <= r_cnt + CNT_STEP;
               if (r_cnt == CNT_LAST) begin
                  r_data_out  <= w_out;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
`ifdef DES_ITER_CBC_EN
                  r_c         <= r_dec ? r_ct : w_res;
`endif
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign data_out  = r_data_out;

endmodule
